// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the board I/O controller: register offsets,
// seven-segment glyph decode and debounce counter sizing.
package io_ctrl_pkg;

  localparam logic [3:0] REG_SW_DATA    = 4'd0;
  localparam logic [3:0] REG_KEY_DATA   = 4'd1;
  localparam logic [3:0] REG_KEY_EDGE   = 4'd2;
  localparam logic [3:0] REG_KEY_IRQ_EN = 4'd3;
  localparam logic [3:0] REG_LED        = 4'd4;
  localparam logic [3:0] REG_HEX_EN     = 4'd5;
  localparam logic [3:0] REG_HEX_MODE   = 4'd6;
  localparam logic [3:0] REG_HEX_VALUE  = 4'd7;
  localparam logic [3:0] REG_HEX_RAW0   = 4'd8;

  // Counter only has to hold 0..DEBOUNCE_CYCLES-1; keep at least one bit.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  // Active-low segments, bit 0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser plus debounce filter for one asynchronous input bit.
// RESET_LEVEL is the pin's idle level; o_level is 1 while the filtered pin is away from idle.
module io_debounce
  import io_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise
);

  localparam int               CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_active;
  logic             w_differs;
  logic             w_accept;

  assign w_active  = r_sync2 ^ RESET_LEVEL;
  assign w_differs = (w_active != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Any cycle agreeing with the accepted level restarts the stability count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      if (!w_differs || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_level <= w_active;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_accept && w_active;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped controller for board switches, keys, LEDs and seven-segment digits.
// Register writes take effect at the clock edge; reads return the pre-write value.
module mmio_io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int NUM_LED         = 10,
  parameter int NUM_HEX         = 6,
  parameter int DATA_W          = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [3:0]           bus_addr,
  input  logic [DATA_W-1:0]    bus_wdata,
  input  logic                 bus_we,
  input  logic                 bus_re,
  output logic [DATA_W-1:0]    bus_rdata,
  output logic                 bus_rvalid,
  input  logic [NUM_SW-1:0]    sw_in,
  input  logic [NUM_KEY-1:0]   key_n_in,
  output logic [NUM_LED-1:0]   led_out,
  output logic [7*NUM_HEX-1:0] hex_out,
  output logic                 irq
);

  logic [NUM_SW-1:0]        w_sw_db;
  logic [NUM_KEY-1:0]       w_key_db, w_key_rise, w_edge_clr, w_key_edge_next, w_irq_en_next;
  logic [NUM_LED-1:0]       w_led_next;
  logic [NUM_HEX-1:0]       w_hex_en_next, w_hex_mode_next;
  logic [4*NUM_HEX-1:0]     w_hex_value_next;
  logic [NUM_HEX-1:0][6:0]  w_hex_raw_next;
  logic [7*NUM_HEX-1:0]     w_hex_out_next;
  logic [DATA_W-1:0]        w_rdata;

  logic [NUM_KEY-1:0]       r_key_edge, r_irq_en;
  logic [NUM_LED-1:0]       r_led;
  logic [NUM_HEX-1:0]       r_hex_en, r_hex_mode;
  logic [4*NUM_HEX-1:0]     r_hex_value;
  logic [NUM_HEX-1:0][6:0]  r_hex_raw;
  logic [7*NUM_HEX-1:0]     r_hex_out;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_rvalid, r_irq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_db (
        .i_clk(CLOCK_50), .i_rst(reset), .i_din(sw_in[gi]),
        .o_level(w_sw_db[gi]), .o_rise()
      );
    end
    // Keys idle high; the filter reports them as active-high "pressed".
    for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_db (
        .i_clk(CLOCK_50), .i_rst(reset), .i_din(key_n_in[gi]),
        .o_level(w_key_db[gi]), .o_rise(w_key_rise[gi])
      );
    end
    // Decode from next-state values so the pins follow a write by one cycle.
    for (gi = 0; gi < NUM_HEX; gi++) begin : g_hex
      assign w_hex_out_next[7*gi +: 7] = !w_hex_en_next[gi]  ? 7'h7F :
                                         w_hex_mode_next[gi] ? w_hex_raw_next[gi] :
                                         hex_to_seg(w_hex_value_next[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    w_irq_en_next    = r_irq_en;
    w_led_next       = r_led;
    w_hex_en_next    = r_hex_en;
    w_hex_mode_next  = r_hex_mode;
    w_hex_value_next = r_hex_value;
    w_hex_raw_next   = r_hex_raw;
    w_edge_clr       = '0;
    if (bus_we) begin
      case (bus_addr)
        REG_KEY_EDGE:   w_edge_clr       = bus_wdata[NUM_KEY-1:0];
        REG_KEY_IRQ_EN: w_irq_en_next    = bus_wdata[NUM_KEY-1:0];
        REG_LED:        w_led_next       = bus_wdata[NUM_LED-1:0];
        REG_HEX_EN:     w_hex_en_next    = bus_wdata[NUM_HEX-1:0];
        REG_HEX_MODE:   w_hex_mode_next  = bus_wdata[NUM_HEX-1:0];
        REG_HEX_VALUE:  w_hex_value_next = bus_wdata[4*NUM_HEX-1:0];
        default: begin
          for (int i = 0; i < NUM_HEX; i++) begin
            if (bus_addr == REG_HEX_RAW0 + 4'(i)) w_hex_raw_next[i] = bus_wdata[6:0];
          end
        end
      endcase
    end
    // A fresh press outranks a simultaneous clear.
    w_key_edge_next = (r_key_edge & ~w_edge_clr) | w_key_rise;
  end

  always_comb begin
    w_rdata = '0;
    case (bus_addr)
      REG_SW_DATA:    w_rdata[NUM_SW-1:0]    = w_sw_db;
      REG_KEY_DATA:   w_rdata[NUM_KEY-1:0]   = w_key_db;
      REG_KEY_EDGE:   w_rdata[NUM_KEY-1:0]   = r_key_edge;
      REG_KEY_IRQ_EN: w_rdata[NUM_KEY-1:0]   = r_irq_en;
      REG_LED:        w_rdata[NUM_LED-1:0]   = r_led;
      REG_HEX_EN:     w_rdata[NUM_HEX-1:0]   = r_hex_en;
      REG_HEX_MODE:   w_rdata[NUM_HEX-1:0]   = r_hex_mode;
      REG_HEX_VALUE:  w_rdata[4*NUM_HEX-1:0] = r_hex_value;
      default: begin
        for (int i = 0; i < NUM_HEX; i++) begin
          if (bus_addr == REG_HEX_RAW0 + 4'(i)) w_rdata[6:0] = r_hex_raw[i];
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_edge  <= '0;
      r_irq_en    <= '0;
      r_led       <= '0;
      r_hex_en    <= '0;
      r_hex_mode  <= '0;
      r_hex_value <= '0;
      r_hex_raw   <= '0;
      r_hex_out   <= '1;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_key_edge  <= w_key_edge_next;
      r_irq_en    <= w_irq_en_next;
      r_led       <= w_led_next;
      r_hex_en    <= w_hex_en_next;
      r_hex_mode  <= w_hex_mode_next;
      r_hex_value <= w_hex_value_next;
      r_hex_raw   <= w_hex_raw_next;
      r_hex_out   <= w_hex_out_next;
      r_irq       <= |(r_key_edge & r_irq_en);
      r_rvalid    <= bus_re;
      if (bus_re) r_rdata <= w_rdata;
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign led_out    = r_led;
  assign hex_out    = r_hex_out;
  assign irq        = r_irq;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl with a window-based debounce model and register scoreboard.
`timescale 1ns/1ps
module tb_mmio_io_ctrl;

  localparam int NUM_SW = 10, NUM_KEY = 4, NUM_LED = 10, NUM_HEX = 6, DC = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [3:0]           bus_addr = '0;
  logic [31:0]          bus_wdata = '0;
  logic                 bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0]          bus_rdata;
  logic                 bus_rvalid;
  logic [NUM_SW-1:0]    sw_in = '0;
  logic [NUM_KEY-1:0]   key_n_in = '1;
  logic [NUM_LED-1:0]   led_out;
  logic [7*NUM_HEX-1:0] hex_out;
  logic                 irq;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mmio_io_ctrl #(.NUM_SW(NUM_SW), .NUM_KEY(NUM_KEY), .NUM_LED(NUM_LED), .NUM_HEX(NUM_HEX),
                 .DATA_W(32), .DEBOUNCE_CYCLES(DC)) dut (
    .CLOCK_50(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .sw_in(sw_in), .key_n_in(key_n_in), .led_out(led_out), .hex_out(hex_out), .irq(irq)
  );

  // Reference model: h_* keep raw samples, newest first; a level is accepted once
  // the synchronised copy (two samples old) has differed for DC consecutive samples.
  logic [NUM_SW-1:0]       h_sw [DC+1];
  logic [NUM_KEY-1:0]      h_key [DC+1];
  logic [NUM_SW-1:0]       m_sw;
  logic [NUM_KEY-1:0]      m_key, m_edge, m_en;
  logic [NUM_LED-1:0]      m_led;
  logic [NUM_HEX-1:0]      m_hen, m_hmode;
  logic [4*NUM_HEX-1:0]    m_hval;
  logic [NUM_HEX-1:0][6:0] m_hraw;
  logic [31:0]             m_rdata;
  logic                    m_rvalid, m_irq;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      4'd0: r[NUM_SW-1:0] = m_sw;
      4'd1: r[NUM_KEY-1:0] = m_key;
      4'd2: r[NUM_KEY-1:0] = m_edge;
      4'd3: r[NUM_KEY-1:0] = m_en;
      4'd4: r[NUM_LED-1:0] = m_led;
      4'd5: r[NUM_HEX-1:0] = m_hen;
      4'd6: r[NUM_HEX-1:0] = m_hmode;
      4'd7: r[4*NUM_HEX-1:0] = m_hval;
      default: if (a >= 4'd8 && a <= 4'd13) r[6:0] = m_hraw[3'(a - 4'd8)];
    endcase
    return r;
  endfunction

  function automatic logic [7*NUM_HEX-1:0] exp_hex();
    logic [7*NUM_HEX-1:0] v;
    for (int i = 0; i < NUM_HEX; i++) begin
      if (!m_hen[i]) v[7*i +: 7] = 7'h7F;
      else if (m_hmode[i]) v[7*i +: 7] = m_hraw[i];
      else v[7*i +: 7] = GLYPH[m_hval[4*i +: 4]];
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [NUM_SW-1:0]  opp_sw, sw_new;
    logic [NUM_KEY-1:0] opp_key, key_new, clr;
    if (reset) begin
      for (int j = 0; j <= DC; j++) begin
        h_sw[j] <= '0;
        h_key[j] <= '0;
      end
      m_sw <= '0; m_key <= '0; m_edge <= '0; m_en <= '0; m_led <= '0;
      m_hen <= '0; m_hmode <= '0; m_hval <= '0; m_hraw <= '0;
      m_rdata <= '0; m_rvalid <= 1'b0; m_irq <= 1'b0;
    end else begin
      opp_sw = '1;
      opp_key = '1;
      for (int j = 1; j <= DC; j++) begin
        opp_sw &= h_sw[j] ^ m_sw;
        opp_key &= h_key[j] ^ m_key;
      end
      sw_new = m_sw ^ opp_sw;
      key_new = m_key ^ opp_key;
      h_sw[0] <= sw_in;
      h_key[0] <= ~key_n_in;
      for (int j = 1; j <= DC; j++) begin
        h_sw[j] <= h_sw[j-1];
        h_key[j] <= h_key[j-1];
      end
      clr = (bus_we && bus_addr == 4'd2) ? bus_wdata[NUM_KEY-1:0] : '0;
      m_edge <= (m_edge & ~clr) | (key_new & ~m_key);
      m_irq <= |(m_edge & m_en);
      m_rvalid <= bus_re;
      if (bus_re) m_rdata <= model_read(bus_addr);
      m_sw <= sw_new;
      m_key <= key_new;
      if (bus_we) begin
        case (bus_addr)
          4'd3: m_en <= bus_wdata[NUM_KEY-1:0];
          4'd4: m_led <= bus_wdata[NUM_LED-1:0];
          4'd5: m_hen <= bus_wdata[NUM_HEX-1:0];
          4'd6: m_hmode <= bus_wdata[NUM_HEX-1:0];
          4'd7: m_hval <= bus_wdata[4*NUM_HEX-1:0];
          default: if (bus_addr >= 4'd8 && bus_addr <= 4'd13) m_hraw[3'(bus_addr - 4'd8)] <= bus_wdata[6:0];
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    bus_addr = a; bus_re = 1'b1;
    tick();
    d = bus_rdata; v = bus_rvalid;
    bus_re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sw_in = NUM_SW'($urandom);
      key_n_in = NUM_KEY'($urandom);
      tick();
    end
    n_checks++;
    if (hex_out !== 42'h3FFFFFFFFFF || led_out !== '0 || irq !== 1'b0 || bus_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: hex=%h led=%h irq=%b rvalid=%b, required hex=3ffffffffff led=0 irq=0 rvalid=0",
               hex_out, led_out, irq, bus_rvalid);
    end
    sw_in = '0;
    key_n_in = '1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: rdata=%h rvalid=%b, required rdata=0 rvalid=1", a, d, v);
      end
      $display("reset read offset %0d -> %h", a, d);
    end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    logic v;
    sw_in = 10'h008;
    for (int i = 0; i < 3; i++) bus_read(4'd0, d, v);
    sw_in = '0;
    for (int i = 0; i < 8; i++) begin
      bus_read(4'd0, d, v);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL debounce_glitch[%0d]: SW_DATA=%h, required 0", i, d);
      end
    end
    sw_in = 10'h008;
    for (int i = 0; i < 7; i++) begin
      bus_read(4'd0, d, v);
      n_checks++;
      if (d !== ((i == 6) ? 32'h8 : 32'h0)) begin
        n_fail++;
        $display("FAIL debounce_accept[%0d]: SW_DATA=%h, required %h", i, d, (i == 6) ? 32'h8 : 32'h0);
      end
    end
    $display("debounce: SW_DATA after stable press = %h", d);
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    logic v;
    bit found;
    bus_write(4'd3, 32'h2);
    key_n_in = 4'b1101;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      bus_read(4'd2, d, v);
      if (d === 32'h2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL edge_set: KEY_EDGE=%h within 20 cycles, required 2", d);
    end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: irq=%b, required 1", irq); end
    bus_read(4'd1, d, v);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL key_data: KEY_DATA=%h, required 2", d); end
    bus_write(4'd2, 32'h0);
    bus_read(4'd2, d, v);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_zero: KEY_EDGE=%h, required 2", d); end
    bus_write(4'd2, 32'h2);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: irq=%b, required 1", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: irq=%b, required 0", irq); end
    key_n_in = '1;
    for (int i = 0; i < 10; i++) tick();
    bus_read(4'd2, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL edge_release: KEY_EDGE=%h, required 0", d); end
    // Press again and land the clear on the very cycle the press is accepted.
    key_n_in = 4'b1101;
    for (int i = 0; i < 5; i++) tick();
    bus_write(4'd2, 32'h2);
    bus_read(4'd2, d, v);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL edge_wins: KEY_EDGE=%h, required 2", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_edge_wins: irq=%b, required 1", irq); end
    $display("edge/irq: KEY_EDGE after same-cycle clear = %h irq=%b", d, irq);
    key_n_in = '1;
    for (int i = 0; i < 8; i++) tick();
    bus_write(4'd2, 32'hF);
    bus_write(4'd3, 32'h0);
    tick();
  endtask

  task automatic test_hex();
    logic [41:0] exp_v;
    bus_write(4'd5, 32'h3F);
    bus_write(4'd7, 32'h00F108);
    bus_write(4'd6, 32'h20);
    bus_write(4'd13, 32'h12);
    exp_v = {7'h12, 7'h40, 7'h0E, 7'h79, 7'h40, 7'h00};
    n_checks++;
    if (hex_out !== exp_v) begin
      n_fail++;
      $display("FAIL hex_mixed: hex_out=%h, required %h", hex_out, exp_v);
    end
    bus_write(4'd5, 32'h3B);
    exp_v = {7'h12, 7'h40, 7'h0E, 7'h7F, 7'h40, 7'h00};
    n_checks++;
    if (hex_out !== exp_v) begin
      n_fail++;
      $display("FAIL hex_disable: hex_out=%h, required %h", hex_out, exp_v);
    end
    $display("hex: hex_out=%h", hex_out);
  endtask

  task automatic test_bus_timing();
    logic [31:0] d;
    logic v;
    bus_addr = 4'd4; bus_wdata = 32'h3FF; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    n_checks++;
    if (bus_rvalid !== 1'b1 || bus_rdata !== 32'h0 || led_out !== 10'h3FF) begin
      n_fail++;
      $display("FAIL rw_same_cycle: rdata=%h rvalid=%b led=%h, required rdata=0 rvalid=1 led=3ff",
               bus_rdata, bus_rvalid, led_out);
    end
    tick();
    n_checks++;
    if (bus_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: rvalid=%b, required 0", bus_rvalid); end
    bus_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'h3FF || v !== 1'b1) begin n_fail++; $display("FAIL led_read: rdata=%h, required 3ff", d); end
    bus_read(4'd15, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: rdata=%h, required 0", d); end
    bus_write(4'd0, 32'hFFFFFFFF);
    bus_read(4'd0, d, v);
    n_checks++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL ro_write: SW_DATA=%h, required 8", d); end
    $display("bus timing: LED=3ff, offset15=0, SW_DATA=%h", d);
  endtask

  task automatic test_random();
    logic [7*NUM_HEX-1:0] eh;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 11) == 0) sw_in[$urandom_range(0, NUM_SW-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) key_n_in[$urandom_range(0, NUM_KEY-1)] ^= 1'b1;
      bus_we = ($urandom_range(0, 2) == 0);
      bus_re = ($urandom_range(0, 1) == 0);
      bus_addr = 4'($urandom_range(0, 15));
      bus_wdata = $urandom;
      tick();
      eh = exp_hex();
      n_checks++;
      if (led_out !== m_led || hex_out !== eh || irq !== m_irq || bus_rvalid !== m_rvalid ||
          (m_rvalid && bus_rdata !== m_rdata)) begin
        n_fail++;
        $display("FAIL random[%0d]: led=%h hex=%h irq=%b rv=%b rd=%h, required led=%h hex=%h irq=%b rv=%b rd=%h",
                 c, led_out, hex_out, irq, bus_rvalid, bus_rdata, m_led, eh, m_irq, m_rvalid, m_rdata);
      end
      if (c % 100 == 0) $display("random cycle %0d: led=%h irq=%b rdata=%h", c, led_out, irq, bus_rdata);
    end
    bus_we = 1'b0;
    bus_re = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    sw_in = 10'h003;
    key_n_in = '1;
    bus_write(4'd4, 32'h155);
    bus_write(4'd5, 32'h3F);
    bus_addr = 4'd4; bus_re = 1'b1;
    tick();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus_rvalid !== 1'b0 || led_out !== '0 || hex_out !== 42'h3FFFFFFFFFF || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rvalid=%b led=%h hex=%h irq=%b, required 0 0 3ffffffffff 0",
               bus_rvalid, led_out, hex_out, irq);
    end
    bus_re = 1'b0;
    sw_in = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    bus_read(4'd0, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mid_sw: SW_DATA=%h, required 0", d); end
    bus_read(4'd4, d, v);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mid_led: LED=%h, required 0", d); end
    $display("mid-operation reset: LED=%h", d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_edge_irq();
    test_hex();
    test_bus_timing();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
Parametrised memory-mapped I/O controller that connects the processor core to the board switches, push-buttons, LEDs and seven-segment displays. It synchronises and debounces the SW and KEY inputs, captures key-press edges with an interrupt, and drives LEDR and HEX0..HEXn from CPU-writable registers. Each HEX digit can show either a hex-decoded nibble or raw segments. It sits between the core's data bus and the top-level board pins.

Parameters:
NUM_SW, 10, number of switch inputs (1..32)
NUM_KEY, 4, number of push-buttons (1..32)
NUM_LED, 10, number of LED outputs (1..32)
NUM_HEX, 6, number of seven-segment digits (1..8)
DATA_W, 32, bus data width
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new input level (10 ms at 50 MHz)

Ports:
CLOCK_50  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset
bus_addr  in  4  word offset of the register
bus_wdata  in  DATA_W  write data
bus_we  in  1  write strobe; single cycle
bus_re  in  1  read strobe; single cycle
bus_rdata  out  DATA_W  registered read data
bus_rvalid  out  1  one-cycle pulse; bus_rdata is valid
sw_in  in  NUM_SW  raw switch levels (asynchronous)
key_n_in  in  NUM_KEY  raw keys, active-low (asynchronous)
led_out  out  NUM_LED  LED drive
hex_out  out  7*NUM_HEX  segments, active-low; digit i occupies bits [7i+6:7i]; bit 0 = segment a
irq  out  1  level interrupt

Behaviour:
- Reset values (all asynchronous): bus_rdata 0, bus_rvalid 0, led_out 0, hex_out all ones (blank), irq 0. All registers are 0. Synchroniser stages: sw 0, key_n 1. Debounced states are 0 (switches off, keys released).
- Input path, per bit:
  - 2-FF synchroniser, then a debounce counter.
  - The counter clears whenever the synchronised level equals the debounced state.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the new level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - Keys are inverted to active-high before debouncing.
- Register map (word offsets; RO = read-only, RW = read/write, RW1C = write-1-to-clear):
  - 0 SW_DATA (RO): debounced switches.
  - 1 KEY_DATA (RO): debounced pressed keys.
  - 2 KEY_EDGE (RW1C): a bit sets when debounced KEY goes 0->1. Writing 1 clears it; writing 0 has no effect.
  - 3 KEY_IRQ_EN (RW).
  - 4 LED (RW, low NUM_LED bits).
  - 5 HEX_EN (RW): per-digit enable. A disabled digit outputs 7'h7F.
  - 6 HEX_MODE (RW): per digit, 0 = decode nibble, 1 = raw segments.
  - 7 HEX_VALUE (RW): nibble i in bits [4i+3:4i].
  - 8..8+NUM_HEX-1 HEX_RAW[i] (RW, 7 bits, active-low segments).
- Unimplemented bits read 0. Unmapped offsets read 0; writes to them are ignored. Writes to RO registers are ignored.
- Read: bus_re in cycle N -> bus_rdata valid with bus_rvalid=1 in cycle N+1. If the read and a write hit the same register in the same cycle, the read returns the pre-write value.
- KEY_EDGE: if a new edge and a W1C of the same bit occur in the same cycle, the edge wins and the bit stays 1.
- irq = registered OR of (KEY_EDGE & KEY_IRQ_EN), one cycle after the flag or enable changes.
- Hex decode: standard 0-F glyphs (0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
- hex_out and led_out are registered. They update one cycle after the write that changes them.
- Reset asserted mid-debounce or mid-read returns everything to reset values; a pending bus_rvalid is dropped.

Decomposition:
- Shared package io_ctrl_pkg holds:
  - register offset localparams (REG_SW_DATA .. REG_HEX_RAW0)
  - the seven-segment decode function (nibble -> 7-bit active-low)
  - the debounce counter width, computed as $clog2(DEBOUNCE_CYCLES)
- One sub-module, io_debounce: single-bit synchroniser plus debounce counter. Parameters DEBOUNCE_CYCLES and RESET_LEVEL. Instantiated NUM_SW + NUM_KEY times via generate.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4.
- Reset: assert reset with inputs toggling -> hex_out=42'h3FFFFFFFFFF, led_out=0, irq=0; reads of all offsets return 0 except KEY_DATA=0.
- Debounce: sw_in[3] pulses high for 3 cycles, then stays high -> SW_DATA stays 0 during the pulse; SW_DATA=0x008 after 2 sync + 4 stable cycles.
- Edge/IRQ:
  - Write KEY_IRQ_EN=0x2, then drive key_n_in[1] low -> KEY_EDGE=0x2, irq=1.
  - Write KEY_EDGE=0x2 -> irq=0 the next cycle.
  - Repeat with the W1C in the same cycle as a new edge -> KEY_EDGE stays 0x2.
- Hex mixed mode: HEX_EN=0x3F, HEX_VALUE=0x00F108, HEX_MODE=0x20, HEX_RAW5=0x12 -> digits 0..4 = 7'h00, 7'h40, 7'h79, 7'h0E, 7'h40; digit 5 = 7'h12.
- Bus timing: write LED=0x3FF and read LED in the same cycle -> rdata=0 with rvalid the next cycle. A second read returns 0x3FF. A read of offset 15 returns 0.
